// File: rtl/sc_rtl_cmp_pkg.sv
// Shared types and default sizes for the SystemC-vs-RTL lockstep comparator.
package sc_rtl_cmp_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;

    // One response sample as produced by either DUT: {bool_o, data_o}.
    typedef struct packed {
        logic                  bool_f;
        logic [DATA_WIDTH-1:0] data;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/sc_rtl_lockstep_cmp_skew_fifo.sv
// Skew-absorbing sample FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate occupancy register.
module skew_fifo
    import sc_rtl_cmp_pkg::*;
#(
    parameter int DEPTH = sc_rtl_cmp_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  sample_t                  data_i,
    input  logic                     pop_i,
    output sample_t                  data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t    wr_ptr_q, wr_ptr_d;
    ptr_t    rd_ptr_q, rd_ptr_d;
    sample_t mem_q [DEPTH];
    logic    do_pop;
    logic    do_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;
    assign drop_o  = push_i && full_o && !do_pop && !clear_i;

    // Next read/write pointers; a clear rewinds both and beats any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample storage write port.
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sc_rtl_lockstep_cmp.sv
// Response-side checker: buffers side A (SystemC) and side B (RTL) streams,
// compares them pairwise in arrival order, and keeps counters, status and
// the first mismatching pair.
module sc_rtl_lockstep_cmp
    import sc_rtl_cmp_pkg::*;
#(
    parameter int DEPTH     = sc_rtl_cmp_pkg::DEPTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear_i,
    input  logic                  a_valid_i,
    input  logic                  a_bool_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  b_valid_i,
    input  logic                  b_bool_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  cmp_valid_o,
    output logic                  mismatch_o,
    output logic [1:0]            status_o,
    output logic                  overflow_o,
    output logic [CNT_WIDTH-1:0]  match_cnt_o,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt_o,
    output logic [DATA_WIDTH:0]   first_bad_a_o,
    output logic [DATA_WIDTH:0]   first_bad_b_o
);

    sample_t    a_head, b_head;
    logic       a_empty, b_empty, a_full, b_full, a_drop, b_drop;
    logic       pop, differs, ovf_evt, cap_load;
    cmp_state_t state_q, state_d;
    logic       cmp_valid_q, cmp_valid_d, mismatch_q, mismatch_d, overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] match_cnt_q, match_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
    sample_t    first_a_q, first_a_d, first_b_q, first_b_d;
    logic [$clog2(DEPTH):0] a_count, b_count;

    skew_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rstn(rstn), .clear_i(clear_i),
        .push_i(a_valid_i), .data_i(sample_t'({a_bool_i, a_data_i})), .pop_i(pop),
        .data_o(a_head), .full_o(a_full), .empty_o(a_empty), .drop_o(a_drop), .count_o(a_count)
    );

    skew_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rstn(rstn), .clear_i(clear_i),
        .push_i(b_valid_i), .data_i(sample_t'({b_bool_i, b_data_i})), .pop_i(pop),
        .data_o(b_head), .full_o(b_full), .empty_o(b_empty), .drop_o(b_drop), .count_o(b_count)
    );

    assign pop     = !a_empty && !b_empty;
    assign differs = (a_head != b_head);
    assign ovf_evt = a_drop || b_drop;

    // Status FSM: first match gives PASS, first mismatch or dropped sample gives FAIL (held).
    always_comb begin
        state_d  = state_q;
        cap_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_PASS: begin
                if (pop && differs) begin
                    state_d  = ST_FAIL;
                    cap_load = 1'b1;
                end else if (ovf_evt) begin
                    state_d  = ST_FAIL;
                end else if (pop && (state_q == ST_IDLE)) begin
                    state_d  = ST_PASS;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
    end

    // Compare result, saturating counters, sticky overflow and first-mismatch capture.
    always_comb begin
        cmp_valid_d    = pop;
        mismatch_d     = pop && differs;
        overflow_d     = overflow_q || ovf_evt;
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        first_a_d      = first_a_q;
        first_b_d      = first_b_q;
        if (pop && !differs && (match_cnt_q != '1))
            match_cnt_d = match_cnt_q + CNT_WIDTH'(1);
        if (pop && differs && (mismatch_cnt_q != '1))
            mismatch_cnt_d = mismatch_cnt_q + CNT_WIDTH'(1);
        if (cap_load) begin
            first_a_d = a_head;
            first_b_d = b_head;
        end
    end

    // Result/status registers; clear_i acts as a synchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            cmp_valid_q    <= 1'b0;
            mismatch_q     <= 1'b0;
            overflow_q     <= 1'b0;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
            first_a_q      <= '0;
            first_b_q      <= '0;
        end else if (clear_i) begin
            state_q        <= ST_IDLE;
            cmp_valid_q    <= 1'b0;
            mismatch_q     <= 1'b0;
            overflow_q     <= 1'b0;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
            first_a_q      <= '0;
            first_b_q      <= '0;
        end else begin
            state_q        <= state_d;
            cmp_valid_q    <= cmp_valid_d;
            mismatch_q     <= mismatch_d;
            overflow_q     <= overflow_d;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            first_a_q      <= first_a_d;
            first_b_q      <= first_b_d;
        end
    end

    assign cmp_valid_o    = cmp_valid_q;
    assign mismatch_o     = mismatch_q;
    assign status_o       = state_q;
    assign overflow_o     = overflow_q;
    assign match_cnt_o    = match_cnt_q;
    assign mismatch_cnt_o = mismatch_cnt_q;
    assign first_bad_a_o  = first_a_q;
    assign first_bad_b_o  = first_b_q;

endmodule

// File: tb/tb_sc_rtl_lockstep_cmp.sv
// Scoreboard bench for sc_rtl_lockstep_cmp: a queue-based reference model
// predicts each compare result and the status outputs; a monitor compares on
// every falling edge.
module tb_sc_rtl_lockstep_cmp;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clear_i;
    logic          a_valid_i, a_bool_i, b_valid_i, b_bool_i;
    logic [DW-1:0] a_data_i, b_data_i;
    logic          cmp_valid_o, mismatch_o, overflow_o;
    logic [1:0]    status_o;
    logic [CW-1:0] match_cnt_o, mismatch_cnt_o;
    logic [DW:0]   first_bad_a_o, first_bad_b_o;

    sc_rtl_lockstep_cmp #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rstn(rstn), .clear_i(clear_i),
        .a_valid_i(a_valid_i), .a_bool_i(a_bool_i), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_bool_i(b_bool_i), .b_data_i(b_data_i),
        .cmp_valid_o(cmp_valid_o), .mismatch_o(mismatch_o), .status_o(status_o),
        .overflow_o(overflow_o), .match_cnt_o(match_cnt_o), .mismatch_cnt_o(mismatch_cnt_o),
        .first_bad_a_o(first_bad_a_o), .first_bad_b_o(first_bad_b_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_pulses = 0;
    int dut_peak_a = 0;

    // Reference model state
    logic [DW:0] qa[$];
    logic [DW:0] qb[$];
    bit          exp_q[$];
    int          m_match, m_mism, m_peak_a;
    bit          m_fail, m_ovf;
    logic [DW:0] m_fa, m_fb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        qa.delete(); qb.delete(); exp_q.delete();
        m_match = 0; m_mism = 0; m_fail = 0; m_ovf = 0; m_fa = '0; m_fb = '0;
    endtask

    function automatic int m_status();
        if (m_fail) return 2;
        if (m_match != 0) return 1;
        return 0;
    endfunction

    // One clock edge of the reference: pairs already waiting are compared first,
    // then each side appends its new sample unless its queue is still full.
    task automatic model_step(input bit av, input logic [DW:0] as, input bit bv,
                              input logic [DW:0] bs, input bit clr);
        if (clr) begin
            m_reset();
            return;
        end
        if (qa.size() > 0 && qb.size() > 0) begin
            logic [DW:0] sa, sb;
            sa = qa.pop_front();
            sb = qb.pop_front();
            if (sa != sb) begin
                if (!m_fail) begin m_fa = sa; m_fb = sb; end
                m_fail = 1;
                if (m_mism < CMAX) m_mism++;
                exp_q.push_back(1'b1);
            end else begin
                if (m_match < CMAX) m_match++;
                exp_q.push_back(1'b0);
            end
        end
        if (av) begin
            if (qa.size() < DEPTH) qa.push_back(as);
            else begin m_ovf = 1; m_fail = 1; end
        end
        if (bv) begin
            if (qb.size() < DEPTH) qb.push_back(bs);
            else begin m_ovf = 1; m_fail = 1; end
        end
        if (qa.size() > m_peak_a) m_peak_a = qa.size();
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, return at the falling edge.
    task automatic step(input bit av, input logic [DW:0] as, input bit bv,
                        input logic [DW:0] bs, input bit clr);
        a_valid_i = av; {a_bool_i, a_data_i} = as;
        b_valid_i = bv; {b_bool_i, b_data_i} = bs;
        clear_i   = clr;
        @(posedge clk);
        model_step(av, as, bv, bs, clr);
        @(negedge clk);
        a_valid_i = 1'b0; b_valid_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: pops the expected result whenever one is due and cross-checks all status outputs.
    always @(negedge clk) begin
        if (rstn) begin
            bit ev;
            bit em;
            ev = (exp_q.size() != 0);
            check("cmp_valid_o", 32'(cmp_valid_o), 32'(ev));
            if (ev) begin
                em = exp_q.pop_front();
                if (cmp_valid_o) check("mismatch_o", 32'(mismatch_o), 32'(em));
            end
            if (cmp_valid_o) n_pulses++;
            if (int'(u_dut.u_fifo_a.count_o) > dut_peak_a) dut_peak_a = int'(u_dut.u_fifo_a.count_o);
            check("status_o", 32'(status_o), 32'(m_status()));
            check("overflow_o", 32'(overflow_o), 32'(m_ovf));
            check("match_cnt_o", 32'(match_cnt_o), 32'(m_match));
            check("mismatch_cnt_o", 32'(mismatch_cnt_o), 32'(m_mism));
            check("first_bad_a_o", 32'(first_bad_a_o), 32'(m_fa));
            check("first_bad_b_o", 32'(first_bad_b_o), 32'(m_fb));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW:0] rnd[20];
        logic [DW:0] va, vb;
        int          ia, ib;
        logic [DW:0] seq[$];

        rstn = 1'b0; clear_i = 1'b0;
        a_valid_i = 1'b0; a_bool_i = 1'b0; a_data_i = '0;
        b_valid_i = 1'b0; b_bool_i = 1'b0; b_data_i = '0;
        m_reset(); m_peak_a = 0;
        repeat (2) @(negedge clk);
        check("reset_status", 32'(status_o), 32'd0);
        check("reset_match_cnt", 32'(match_cnt_o), 32'd0);
        check("reset_cmp_valid", 32'(cmp_valid_o), 32'd0);
        rstn = 1'b1;

        // 1. Equal latency, 0x00..0x0F with bool=1 on both sides.
        n_pulses = 0;
        for (int i = 0; i < 16; i++) step(1'b1, {1'b1, 8'(i)}, 1'b1, {1'b1, 8'(i)}, 1'b0);
        idle(3);
        check("t1_pulses", 32'(n_pulses), 32'd16);
        check("t1_match_cnt", 32'(match_cnt_o), 32'd16);
        check("t1_status_pass", 32'(status_o), 32'd1);
        step(1'b0, '0, 1'b0, '0, 1'b1);

        // 2. B lags A by 3 cycles, 20 random identical samples.
        for (int i = 0; i < 20; i++) rnd[i] = 9'($urandom_range(0, 511));
        m_peak_a = 0; dut_peak_a = 0;
        for (int c = 0; c < 23; c++)
            step(c < 20, (c < 20) ? rnd[c] : 9'h0, c >= 3, (c >= 3) ? rnd[c-3] : 9'h0, 1'b0);
        idle(3);
        check("t2_match_cnt", 32'(match_cnt_o), 32'd20);
        check("t2_overflow", 32'(overflow_o), 32'd0);
        check("t2_status_pass", 32'(status_o), 32'd1);
        check("t2_peak_a", 32'(dut_peak_a), 32'(m_peak_a));
        step(1'b0, '0, 1'b0, '0, 1'b1);

        // 3. Fifth pair differs (0x5B vs 0x5A), seventh differs later.
        for (int i = 0; i < 8; i++) begin
            va = {1'b1, 8'(8'h57 + i)};
            vb = va;
            if (i == 4) vb = 9'h15A;
            if (i == 6) vb = 9'h100;
            step(1'b1, va, 1'b1, vb, 1'b0);
        end
        idle(3);
        check("t3_status_fail", 32'(status_o), 32'd2);
        check("t3_first_bad_a", 32'(first_bad_a_o), 32'h15B);
        check("t3_first_bad_b", 32'(first_bad_b_o), 32'h15A);
        check("t3_mismatch_cnt", 32'(mismatch_cnt_o), 32'd2);
        step(1'b0, '0, 1'b0, '0, 1'b1);

        // 4. Nine A samples with B idle, then B sends the first eight.
        for (int i = 0; i < 9; i++) step(1'b1, {1'b0, 8'(i * 3)}, 1'b0, '0, 1'b0);
        check("t4_overflow", 32'(overflow_o), 32'd1);
        check("t4_status_fail", 32'(status_o), 32'd2);
        check("t4_first_bad_zero", 32'(first_bad_a_o), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, {1'b0, 8'(i * 3)}, 1'b0);
        idle(3);
        check("t4_match_cnt", 32'(match_cnt_o), 32'd8);
        check("t4_first_bad_b_zero", 32'(first_bad_b_o), 32'd0);
        step(1'b0, '0, 1'b0, '0, 1'b1);

        // 5. Data equal, bool differs.
        step(1'b1, 9'h0A5, 1'b1, 9'h1A5, 1'b0);
        idle(2);
        check("t5_mismatch_cnt", 32'(mismatch_cnt_o), 32'd1);
        step(1'b0, '0, 1'b0, '0, 1'b1);

        // 6. Clear with 4 entries buffered; the sample offered during the clear is discarded.
        for (int i = 0; i < 4; i++) step(1'b1, {1'b1, 8'(i)}, 1'b0, '0, 1'b0);
        check("t6_pre_count_a", 32'(u_dut.u_fifo_a.count_o), 32'd4);
        step(1'b1, 9'h111, 1'b1, 9'h111, 1'b1);
        check("t6_clr_count_a", 32'(u_dut.u_fifo_a.count_o), 32'd0);
        check("t6_clr_count_b", 32'(u_dut.u_fifo_b.count_o), 32'd0);
        check("t6_clr_status", 32'(status_o), 32'd0);
        idle(2);
        // Async reset pulse mid-stream, issued in the low phase.
        for (int i = 0; i < 3; i++) step(1'b1, {1'b0, 8'(i)}, 1'b1, {1'b1, 8'(i)}, 1'b0);
        #2 rstn = 1'b0;
        m_reset();
        #1;
        check("t6_rst_count_a", 32'(u_dut.u_fifo_a.count_o), 32'd0);
        check("t6_rst_cmp_valid", 32'(cmp_valid_o), 32'd0);
        check("t6_rst_mismatch_cnt", 32'(mismatch_cnt_o), 32'd0);
        check("t6_rst_status", 32'(status_o), 32'd0);
        #1 rstn = 1'b1;
        @(negedge clk);
        idle(3);

        // Random phase: shared reference stream, independent valids, rare corruption and clears.
        seq.delete();
        for (int i = 0; i < 400; i++) seq.push_back(9'($urandom_range(0, 511)));
        ia = 0; ib = 0;
        for (int c = 0; c < 300; c++) begin
            bit av, bv, clr;
            av  = ($urandom_range(0, 99) < 60) && (ia < 400);
            bv  = ($urandom_range(0, 99) < 55) && (ib < 400);
            clr = ($urandom_range(0, 99) < 2);
            va  = av ? seq[ia] : 9'h0;
            vb  = bv ? seq[ib] : 9'h0;
            if (bv && $urandom_range(0, 99) < 3) vb = vb ^ 9'h001;
            step(av, va, bv, vb, clr);
            if (av) ia++;
            if (bv) ib++;
        end
        idle(DEPTH + 2);
        check("end_count_a", 32'(u_dut.u_fifo_a.count_o), 32'(qa.size()));
        check("end_count_b", 32'(u_dut.u_fifo_b.count_o), 32'(qb.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
